memory_island_bank_arbiter: RTL and testbench
=============================================

# memory_island_bank_arbiter

Per-bank access scheduler for the memory island. It shares one SRAM bank between NumNarrow narrow requester ports and one wide requester port, using round-robin among the narrow ports and default priority for the wide port. A bounded starvation guard stops continuous wide traffic from locking out the narrow ports. The block tracks each granted access through the fixed bank read latency and returns the response valid to the port that issued it.

## Interface
- NumNarrow, 4, number of narrow requester ports (≥2)
- AddrWidth, 10, bank word address width
- DataWidth, 64, bank data width; both narrow and wide ports are pre-aligned to it
- BankLatency, 1, SRAM read latency in cycles (1..4)
- MaxNarrowStall, 7, maximum consecutive cycles a pending narrow request may lose to the wide port (1..255)

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  **One clock; reset is asynchronous and active-high.**
- narrow_req_i  in  NumNarrow  per-port request
- narrow_we_i  in  NumNarrow  per-port write enable
- narrow_addr_i  in  NumNarrow×AddrWidth  per-port address
- narrow_wdata_i  in  NumNarrow×DataWidth  per-port write data
- narrow_be_i  in  NumNarrow×DataWidth/8  per-port byte enables
- narrow_gnt_o  out  NumNarrow  one-hot grant, or all zero
- narrow_rvalid_o  out  NumNarrow  response valid; carries read data for reads and acknowledges writes
- wide_req_i, wide_we_i  in  1  wide request and write enable
- wide_addr_i, wide_wdata_i, wide_be_i  in  AddrWidth / DataWidth / DataWidth/8  wide request payload
- wide_gnt_o, wide_rvalid_o  out  1  wide grant and response valid
- bank_ready_i  in  1  bank can accept an access this cycle
- bank_req_o, bank_we_o  out  1  bank access and write enable
- bank_addr_o, bank_wdata_o, bank_be_o  out  AddrWidth / DataWidth / DataWidth/8  payload of the selected requester
- bank_rdata_i  in  DataWidth  bank read data, valid BankLatency cycles after the access
- rdata_o  out  DataWidth  bank_rdata_i passed through and broadcast to all ports; qualified by the rvalid outputs

## Operation
- Grant condition: at most one grant per cycle, and only when bank_ready_i=1. With bank_ready_i=0 all grants and bank_req_o are 0.
- Winner selection:
  - The wide port wins whenever wide_req_i=1, unless the stall counter has reached MaxNarrowStall.
  - When stall_cnt==MaxNarrowStall and any narrow request is pending, a narrow port wins.
  - Otherwise the narrow round-robin winner is granted.
- Round-robin:
  - The winner is the lowest index ≥ rr_q among requesting narrow ports, wrapping to index 0.
  - On a narrow grant, rr_q ← (winner+1) mod NumNarrow.
  - rr_q is unchanged on wide grants and on idle cycles.
- Stall counter (8 bit, saturating at MaxNarrowStall):
  - Increments in a cycle where a narrow request is pending, no narrow grant is given, and bank_ready_i=1.
  - Clears on any narrow grant, and in any cycle with no narrow request pending.
  - Holds while bank_ready_i=0.
- Bank mux: bank_req_o = |grants. The bank_* payload is taken from the winner. The payload is don't-care when bank_req_o=0; the implementation drives the wide payload.
- Response tracking:
  - A BankLatency-deep shift register carries {valid, is_wide, idx} of each granted access.
  - At the tail stage, the selected rvalid output is asserted for one cycle.
  - Every granted access, read or write, produces exactly one rvalid.
- Reset:
  - rr_q=0, stall_cnt=0, all pipeline valid bits 0.
  - All grant, rvalid and bank_req_o outputs are 0 while rst_i=1.
  - Reset asserted mid-operation discards in-flight responses: no rvalid is produced for them after reset.

## Timing
- Grants are combinational from req and bank_ready_i, in the same cycle. A requester holds req and payload stable until granted.
- bank_req_o and payload are asserted in the grant cycle.
- rvalid rises exactly BankLatency cycles after the grant edge and lasts one cycle. rdata_o is valid in the same cycle.
- Back-to-back grants give back-to-back rvalids. Throughput is 1 access/cycle.
- Simultaneous wide request and saturated stall counter: the narrow port wins, the counter clears, and the wide port wins the next cycle.
- A requester that drops req before being granted does not affect rr_q.
- Deassertion of rst_i: the first grant is possible in the first cycle after release.

## Test plan
- Idle after reset (BankLatency=1): narrow_req_i=4'b0101 held -> grants on ports 0, 2, 0, 2 in successive cycles; each port's rvalid follows one cycle after its grant; rr_q after the first grant is 1.
- Wide flood: wide_req_i=1 continuously, narrow_req_i[3]=1 from cycle 0, MaxNarrowStall=7 -> wide granted in cycles 0–6, port 3 granted in cycle 7, wide granted in cycle 8.
- Backpressure: bank_ready_i=0 for 5 cycles with wide and narrow requests pending -> no grants, stall_cnt held; wide granted in the first ready cycle.
- Latency sweep: BankLatency=3; a write to addr 0x10 then a read of 0x10 from port 1 -> rvalid for port 1 in cycles g+3 and g+4; read data equals the written value.
- Wrap-around: rr_q=3 with narrow_req_i=4'b1001 -> port 3 is granted, then port 0, then port 3.
- Reset mid-flight: BankLatency=2, reset asserted one cycle after a grant -> no rvalid appears afterwards; rr_q=0 after reset.

Source files
------------

// File: rtl/memory_island_bank_arbiter.sv
// rtl/memory_island_bank_arbiter.sv - one SRAM bank shared by round-robin narrow ports and a priority wide port.
// Wide traffic wins by default; a saturating stall counter hands the bank to a waiting narrow port.
module memory_island_bank_arbiter #(
   parameter int NumNarrow      = 4,
   parameter int AddrWidth      = 10,
   parameter int DataWidth      = 64,
   parameter int BankLatency    = 1,
   parameter int MaxNarrowStall = 7
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NumNarrow-1:0]             narrow_req_i,
   input  logic [NumNarrow-1:0]             narrow_we_i,
   input  logic [NumNarrow*AddrWidth-1:0]   narrow_addr_i,
   input  logic [NumNarrow*DataWidth-1:0]   narrow_wdata_i,
   input  logic [NumNarrow*DataWidth/8-1:0] narrow_be_i,
   output logic [NumNarrow-1:0]             narrow_gnt_o,
   output logic [NumNarrow-1:0]             narrow_rvalid_o,
   input  logic                             wide_req_i,
   input  logic                             wide_we_i,
   input  logic [AddrWidth-1:0]             wide_addr_i,
   input  logic [DataWidth-1:0]             wide_wdata_i,
   input  logic [DataWidth/8-1:0]           wide_be_i,
   output logic                             wide_gnt_o,
   output logic                             wide_rvalid_o,
   input  logic                             bank_ready_i,
   output logic                             bank_req_o,
   output logic                             bank_we_o,
   output logic [AddrWidth-1:0]             bank_addr_o,
   output logic [DataWidth-1:0]             bank_wdata_o,
   output logic [DataWidth/8-1:0]           bank_be_o,
   input  logic [DataWidth-1:0]             bank_rdata_i,
   output logic [DataWidth-1:0]             rdata_o
);
   localparam int IdxWidth = $clog2(NumNarrow);
   localparam int BeWidth  = DataWidth / 8;

   logic [IdxWidth-1:0]  rr_q;
   logic [IdxWidth-1:0]  rr_winner;
   logic [IdxWidth-1:0]  rr_next;
   logic [7:0]           stall_cnt;
   logic [NumNarrow-1:0] hi_mask;
   logic [NumNarrow-1:0] hi_req;
   logic [NumNarrow-1:0] pick;
   logic                 narrow_any;
   logic                 starve;
   logic                 wide_win;
   logic                 narrow_win;

   logic [BankLatency-1:0] pipe_valid;
   logic [BankLatency-1:0] pipe_wide;
   logic [IdxWidth-1:0]    pipe_idx [BankLatency];

   // Requests at or above the pointer take precedence; otherwise wrap to the lowest index.
   always_comb begin
      hi_mask = '0;
      for (int k = 0; k < NumNarrow; k++) begin
         hi_mask[k] = (k >= int'(rr_q));
      end
      hi_req    = narrow_req_i & hi_mask;
      pick      = (|hi_req) ? hi_req : narrow_req_i;
      rr_winner = '0;
      for (int k = NumNarrow - 1; k >= 0; k--) begin
         if (pick[k]) begin
            rr_winner = IdxWidth'(k);
         end
      end
   end

   assign rr_next    = (rr_winner == IdxWidth'(NumNarrow - 1)) ? '0 : rr_winner + 1'b1;
   assign narrow_any = |narrow_req_i;
   assign starve     = (stall_cnt == 8'(MaxNarrowStall)) && narrow_any;
   assign wide_win   = !rst_i && bank_ready_i && wide_req_i && !starve;
   assign narrow_win = !rst_i && bank_ready_i && narrow_any && !wide_win;

   always_comb begin
      narrow_gnt_o = '0;
      if (narrow_win) begin
         narrow_gnt_o[rr_winner] = 1'b1;
      end
   end

   assign wide_gnt_o   = wide_win;
   assign bank_req_o   = wide_win | narrow_win;
   assign bank_we_o    = narrow_win ? narrow_we_i[rr_winner] : wide_we_i;
   assign bank_addr_o  = narrow_win ? narrow_addr_i[rr_winner*AddrWidth +: AddrWidth] : wide_addr_i;
   assign bank_wdata_o = narrow_win ? narrow_wdata_i[rr_winner*DataWidth +: DataWidth] : wide_wdata_i;
   assign bank_be_o    = narrow_win ? narrow_be_i[rr_winner*BeWidth +: BeWidth] : wide_be_i;
   assign rdata_o      = bank_rdata_i;

   // A stalled cycle only counts when the bank could have served the narrow port.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q      <= '0;
         stall_cnt <= '0;
      end else begin
         if (narrow_win) begin
            rr_q <= rr_next;
         end
         if (!narrow_any || narrow_win) begin
            stall_cnt <= '0;
         end else if (bank_ready_i && stall_cnt != 8'(MaxNarrowStall)) begin
            stall_cnt <= stall_cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pipe_valid <= '0;
         pipe_wide  <= '0;
         for (int s = 0; s < BankLatency; s++) begin
            pipe_idx[s] <= '0;
         end
      end else begin
         pipe_valid[0] <= bank_req_o;
         pipe_wide[0]  <= wide_win;
         pipe_idx[0]   <= rr_winner;
         for (int s = 1; s < BankLatency; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_wide[s]  <= pipe_wide[s-1];
            pipe_idx[s]   <= pipe_idx[s-1];
         end
      end
   end

   assign wide_rvalid_o = pipe_valid[BankLatency-1] && pipe_wide[BankLatency-1];

   always_comb begin
      narrow_rvalid_o = '0;
      if (pipe_valid[BankLatency-1] && !pipe_wide[BankLatency-1]) begin
         narrow_rvalid_o[pipe_idx[BankLatency-1]] = 1'b1;
      end
   end
endmodule

// File: tb/tb_memory_island_bank_arbiter.sv
// tb/tb_memory_island_bank_arbiter.sv - randomized and directed checks of the bank arbiter against a cycle model.
module tb_memory_island_bank_arbiter;
   localparam int N    = 4;
   localparam int AW   = 10;
   localparam int DW   = 64;
   localparam int BW   = DW / 8;
   localparam int LAT  = 2;
   localparam int MAXS = 7;
   localparam int OW   = 2*N + 4 + AW;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0]    nreq, nwe, narrow_gnt, narrow_rvalid;
   logic [N*AW-1:0] naddr;
   logic [N*DW-1:0] nwdata;
   logic [N*BW-1:0] nbe;
   logic            wreq, wwe, wide_gnt, wide_rvalid, ready, bank_req, bank_we;
   logic [AW-1:0]   waddr, bank_addr;
   logic [DW-1:0]   wwdata, bank_wdata, bank_rdata, rdata;
   logic [BW-1:0]   wbe, bank_be;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   memory_island_bank_arbiter #(
      .NumNarrow(N), .AddrWidth(AW), .DataWidth(DW), .BankLatency(LAT), .MaxNarrowStall(MAXS)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .narrow_req_i(nreq), .narrow_we_i(nwe), .narrow_addr_i(naddr), .narrow_wdata_i(nwdata),
      .narrow_be_i(nbe), .narrow_gnt_o(narrow_gnt), .narrow_rvalid_o(narrow_rvalid),
      .wide_req_i(wreq), .wide_we_i(wwe), .wide_addr_i(waddr), .wide_wdata_i(wwdata),
      .wide_be_i(wbe), .wide_gnt_o(wide_gnt), .wide_rvalid_o(wide_rvalid),
      .bank_ready_i(ready), .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
      .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata), .rdata_o(rdata)
   );

   // SRAM stand-in driven by the DUT's bank port
   logic [DW-1:0] sram  [0:(1<<AW)-1];
   logic [DW-1:0] rpipe [LAT];
   always @(posedge clk) begin
      if (bank_req && bank_we)
         for (int b = 0; b < BW; b++)
            if (bank_be[b]) sram[bank_addr][b*8 +: 8] <= bank_wdata[b*8 +: 8];
      rpipe[0] <= (bank_req && !bank_we) ? sram[bank_addr] : '0;
      for (int s = 1; s < LAT; s++) rpipe[s] <= rpipe[s-1];
   end
   assign bank_rdata = rpipe[LAT-1];

   // Reference model: pointer, stall count, memory image, and a ring of expected responses by cycle
   int            m_rr, m_stall, cyc;
   logic [DW-1:0] m_mem [0:(1<<AW)-1];
   logic          r_v [64], r_w [64], r_rd [64];
   int            r_idx [64];
   logic [DW-1:0] r_data [64];

   int            e_win;
   logic [N-1:0]  e_ngnt, e_nrv;
   logic          e_wgnt, e_wrv, e_rd, e_we;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wd, e_rdata;
   logic [BW-1:0] e_be;
   logic [OW-1:0] obs, expv;

   task automatic model_reset();
      for (int i = 0; i < 64; i++) r_v[i] = 1'b0;
      m_rr    = 0;
      m_stall = 0;
   endtask

   task automatic model_eval();
      int s;
      s      = cyc % 64;
      e_win  = -1;
      e_ngnt = '0;
      e_wgnt = 1'b0;
      if (!rst && ready) begin
         if (wreq && !(m_stall == MAXS && nreq != 0)) e_win = N;
         else
            for (int k = 0; k < N; k++)
               if (e_win < 0 && nreq[(m_rr + k) % N]) e_win = (m_rr + k) % N;
      end
      if (e_win == N) e_wgnt = 1'b1;
      else if (e_win >= 0) e_ngnt[e_win] = 1'b1;
      if (e_win >= 0 && e_win < N) begin
         e_we = nwe[e_win]; e_addr = naddr[e_win*AW +: AW];
         e_wd = nwdata[e_win*DW +: DW]; e_be = nbe[e_win*BW +: BW];
      end else begin
         e_we = wwe; e_addr = waddr; e_wd = wwdata; e_be = wbe;
      end
      e_nrv   = '0;
      e_wrv   = 1'b0;
      e_rd    = r_v[s] && r_rd[s];
      e_rdata = r_data[s];
      if (r_v[s]) begin
         if (r_w[s]) e_wrv = 1'b1;
         else e_nrv[r_idx[s]] = 1'b1;
      end
   endtask

   task automatic model_commit();
      int s, d;
      s = cyc % 64;
      d = (cyc + LAT) % 64;
      r_v[s] = 1'b0;
      if (!rst) begin
         if (e_win >= 0) begin
            r_v[d] = 1'b1; r_w[d] = (e_win == N); r_idx[d] = e_win;
            r_rd[d] = !e_we; r_data[d] = m_mem[e_addr];
            if (e_we)
               for (int b = 0; b < BW; b++)
                  if (e_be[b]) m_mem[e_addr][b*8 +: 8] = e_wd[b*8 +: 8];
         end
         if (nreq == 0) m_stall = 0;
         else if (ready) begin
            if (e_win >= 0 && e_win < N) m_stall = 0;
            else if (m_stall < MAXS) m_stall++;
         end
         if (e_win >= 0 && e_win < N) m_rr = (e_win + 1) % N;
      end
      cyc++;
   endtask

   task automatic eval_cycle();
      @(negedge clk);
      model_eval();
      vectors++;
      obs  = {narrow_gnt, wide_gnt, narrow_rvalid, wide_rvalid, bank_req, bank_we, bank_addr};
      expv = {e_ngnt, e_wgnt, e_nrv, e_wrv, (e_win >= 0), e_we, e_addr};
   endtask

   task automatic end_cycle();
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic set_port(input int i, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [BW-1:0] be);
      nreq[i] = 1'b1; nwe[i] = we; naddr[i*AW +: AW] = a;
      nwdata[i*DW +: DW] = d; nbe[i*BW +: BW] = be;
   endtask

   task automatic idle_cycle();
      nreq = '0; wreq = 1'b0; ready = 1'b1;
      eval_cycle();
      if (obs !== expv) begin errors++; $display("FAIL idle got %h exp %h", obs, expv); end
      end_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1; ready = 1'b1; wreq = 1'b1; wwe = 1'b0; waddr = 10'h3; wwdata = '0; wbe = '1;
      for (int i = 0; i < N; i++) set_port(i, 1'b0, AW'(i), '0, '1);
      for (int c = 0; c < 2; c++) begin
         eval_cycle();
         if (obs !== expv) begin errors++; $display("FAIL reset_model got %h exp %h", obs, expv); end
         vectors++;
         if ({narrow_gnt, wide_gnt, bank_req, narrow_rvalid, wide_rvalid} !== '0) begin
            errors++; $display("FAIL reset_outputs got %b exp 0", {narrow_gnt, wide_gnt, bank_req});
         end
         end_cycle();
      end
      rst = 1'b0;
      eval_cycle();
      if (obs !== expv) begin errors++; $display("FAIL reset_release got %h exp %h", obs, expv); end
      vectors++;
      if (wide_gnt !== 1'b1) begin errors++; $display("FAIL reset_first_grant got %b exp 1", wide_gnt); end
      end_cycle();
   endtask

   task automatic test_alternate();
      int seq [4] = '{0, 2, 0, 2};
      nreq = '0; wreq = 1'b0;
      set_port(0, 1'b0, 10'h1, '0, '1);
      set_port(2, 1'b0, 10'h2, '0, '1);
      for (int c = 0; c < 4; c++) begin
         eval_cycle();
         if (obs !== expv) begin errors++; $display("FAIL alternate got %h exp %h", obs, expv); end
         vectors++;
         if (narrow_gnt !== N'(1 << seq[c])) begin
            errors++; $display("FAIL alternate_seq cycle %0d got %b exp %b", c, narrow_gnt, N'(1 << seq[c]));
         end
         end_cycle();
      end
      idle_cycle();
   endtask

   task automatic test_wide_flood();
      idle_cycle();
      wreq = 1'b1; wwe = 1'b0; waddr = 10'h20;
      set_port(3, 1'b0, 10'h5, '0, '1);
      for (int c = 0; c < 10; c++) begin
         eval_cycle();
         if (obs !== expv) begin errors++; $display("FAIL flood got %h exp %h", obs, expv); end
         vectors++;
         if ({narrow_gnt, wide_gnt} !== ((c == 7) ? 5'b10000 : 5'b00001)) begin
            errors++; $display("FAIL flood_seq cycle %0d got %b", c, {narrow_gnt, wide_gnt});
         end
         end_cycle();
         if (e_win == 3) nreq[3] = 1'b0;
      end
      idle_cycle();
   endtask

   task automatic test_backpressure();
      idle_cycle();
      wreq = 1'b1; ready = 1'b0;
      set_port(1, 1'b1, 10'h7, 64'h1111, '1);
      for (int c = 0; c < 6; c++) begin
         if (c == 5) ready = 1'b1;
         eval_cycle();
         if (obs !== expv) begin errors++; $display("FAIL backpressure got %h exp %h", obs, expv); end
         vectors++;
         if ({narrow_gnt, wide_gnt, bank_req} !== ((c == 5) ? 6'b000011 : 6'b0)) begin
            errors++; $display("FAIL backpressure_gnt cycle %0d got %b", c, {narrow_gnt, wide_gnt, bank_req});
         end
         end_cycle();
      end
      wreq = 1'b0;
      eval_cycle();
      if (obs !== expv) begin errors++; $display("FAIL backpressure_after got %h exp %h", obs, expv); end
      end_cycle();
      idle_cycle();
   endtask

   task automatic test_latency();
      logic [DW-1:0] d;
      d = 64'hDEAD_BEEF_0123_4567;
      idle_cycle();
      for (int c = 0; c < 2; c++) begin
         nreq = '0;
         set_port(1, (c == 0), 10'h10, d, '1);
         eval_cycle();
         if (obs !== expv) begin errors++; $display("FAIL latency_grant got %h exp %h", obs, expv); end
         end_cycle();
      end
      nreq = '0;
      for (int j = 0; j < LAT + 2; j++) begin
         eval_cycle();
         if (obs !== expv) begin errors++; $display("FAIL latency_resp got %h exp %h", obs, expv); end
         vectors++;
         if (e_rd && rdata !== e_rdata) begin
            errors++; $display("FAIL latency_model_data got %h exp %h", rdata, e_rdata);
         end
         if (j == LAT - 1) begin
            vectors++;
            if (narrow_rvalid !== 4'b0010 || rdata !== d) begin
               errors++; $display("FAIL latency_readback got %b/%h exp 0010/%h", narrow_rvalid, rdata, d);
            end
         end
         end_cycle();
      end
   endtask

   task automatic test_wrap();
      int seq [3] = '{3, 0, 3};
      idle_cycle();
      set_port(2, 1'b0, 10'h2, '0, '1);
      eval_cycle();
      if (obs !== expv) begin errors++; $display("FAIL wrap_setup got %h exp %h", obs, expv); end
      end_cycle();
      nreq = '0;
      set_port(0, 1'b0, 10'h8, '0, '1);
      set_port(3, 1'b0, 10'h9, '0, '1);
      for (int c = 0; c < 3; c++) begin
         eval_cycle();
         if (obs !== expv) begin errors++; $display("FAIL wrap got %h exp %h", obs, expv); end
         vectors++;
         if (narrow_gnt !== N'(1 << seq[c])) begin
            errors++; $display("FAIL wrap_seq cycle %0d got %b exp %b", c, narrow_gnt, N'(1 << seq[c]));
         end
         end_cycle();
      end
      idle_cycle();
   endtask

   task automatic test_random();
      nreq = '0; wreq = 1'b0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!nreq[i] && $urandom_range(2) == 0)
               set_port(i, 1'($urandom), AW'($urandom_range(15)), {$urandom, $urandom}, BW'($urandom));
         if (!wreq && $urandom_range(1) == 0) begin
            wreq = 1'b1; wwe = 1'($urandom); waddr = AW'($urandom_range(15));
            wwdata = {$urandom, $urandom}; wbe = BW'($urandom);
         end
         ready = ($urandom_range(4) != 0);
         eval_cycle();
         if (obs !== expv) begin errors++; $display("FAIL random cycle %0d got %h exp %h", c, obs, expv); end
         if (e_rd && rdata !== e_rdata) begin
            errors++; $display("FAIL random_data cycle %0d got %h exp %h", c, rdata, e_rdata);
         end
         end_cycle();
         if (e_win == N) wreq = 1'b0;
         else if (e_win >= 0) nreq[e_win] = 1'b0;
      end
      nreq = '0; wreq = 1'b0; ready = 1'b1;
      for (int c = 0; c < LAT + 1; c++) idle_cycle();
   endtask

   task automatic test_reset_midflight();
      idle_cycle();
      set_port(1, 1'b0, 10'h10, '0, '1);
      eval_cycle();
      if (obs !== expv) begin errors++; $display("FAIL midflight_grant got %h exp %h", obs, expv); end
      end_cycle();
      nreq = '0;
      rst  = 1'b1;
      model_reset();
      for (int c = 0; c < LAT + 3; c++) begin
         eval_cycle();
         if (obs !== expv) begin errors++; $display("FAIL midflight got %h exp %h", obs, expv); end
         vectors++;
         if ({narrow_rvalid, wide_rvalid} !== '0) begin
            errors++; $display("FAIL midflight_rvalid cycle %0d got %b exp 0", c, {narrow_rvalid, wide_rvalid});
         end
         end_cycle();
         if (c == 1) rst = 1'b0;
      end
      set_port(1, 1'b0, 10'h1, '0, '1);
      set_port(2, 1'b0, 10'h2, '0, '1);
      eval_cycle();
      if (obs !== expv) begin errors++; $display("FAIL midflight_rr got %h exp %h", obs, expv); end
      vectors++;
      if (narrow_gnt !== 4'b0010) begin errors++; $display("FAIL midflight_rr_ptr got %b exp 0010", narrow_gnt); end
      end_cycle();
      nreq = '0;
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         sram[i]  = '0;
         m_mem[i] = '0;
      end
      for (int s = 0; s < LAT; s++) rpipe[s] = '0;
      for (int i = 0; i < 64; i++) begin
         r_w[i] = 1'b0; r_rd[i] = 1'b0; r_idx[i] = 0; r_data[i] = '0;
      end
      model_reset();
      cyc = 0;
      nreq = '0; nwe = '0; naddr = '0; nwdata = '0; nbe = '0;
      wreq = 1'b0; wwe = 1'b0; waddr = '0; wwdata = '0; wbe = '0; ready = 1'b1; rst = 1'b1;
      test_reset();
      test_alternate();
      test_wide_flood();
      test_backpressure();
      test_latency();
      test_wrap();
      test_random();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
